gpp_multicycle: RTL
===================

# gpp_multicycle

Parametrised multi-cycle MIPS-subset core: the next generation of the team's general-purpose processor. It adds the following over the previous generation:
- an instruction-fetch handshake instead of a hard-wired instruction;
- R-type and I-type ALU ops plus BEQ;
- configurable data width and register count;
- a carry flag, an illegal-instruction halt, a retire strobe and a debug register read port.

It sits between the instruction memory and the test bench / debug logic.

## Interface
- DATA_W, 32, datapath and register width; legal range 16..64.
- REG_COUNT, 32, number of architectural registers; legal range 2..32; register 0 reads as zero.
- PC_W, 32, program-counter width.
- RESET_PC, 0, PC value loaded on reset.
- Clk  input  1  sole clock; all state updates on the rising edge.
- Rst  input  1  reset, synchronous, active-low.
- IReq  output  1  instruction request; high for every cycle in S_FETCH.
- IAddr  output  PC_W  byte address of the requested instruction; equals PC.
- IValid  input  1  IData valid this cycle.
- IData  input  32  instruction word.
- DbgAddr  input  5  debug register index.
- DbgData  output  DATA_W  combinational read of regi[DbgAddr]; 0 if DbgAddr >= REG_COUNT.
- Retire  output  1  one-cycle pulse when an instruction completes.
- Co  output  1  carry/borrow flag from the last ADD, ADDI or SUB.
- Halt  output  1  core stopped on an illegal instruction.

## Operation
- Fields:
  - op=IR[31:26], rs=IR[25:21], rt=IR[20:16], rd=IR[15:11], sh=IR[10:6], fn=IR[5:0], imm=IR[15:0].
  - simm = imm sign-extended to DATA_W; zimm = imm zero-extended.
- States: S_WAIT, S_FETCH, S_DECODE, S_EXECUTE, S_STORE, S_HALT.
- S_WAIT: one cycle, then S_FETCH.
- S_FETCH:
  - IReq=1.
  - On an edge with IValid=1, latch IData into IR and go to S_DECODE.
  - Otherwise stay; no timeout.
- S_DECODE:
  - Latch rsv=regi[rs] and rtv=regi[rt].
  - If the opcode/funct is unsupported, or any used register index is >= REG_COUNT, go to S_HALT.
  - Otherwise go to S_EXECUTE.
- S_EXECUTE: compute rdv, Co and the branch decision, then S_STORE.
  - op 0, fn 0x20 ADD: {Co,rdv}=rsv+rtv.
  - op 0, fn 0x22 SUB: rdv=rsv-rtv; Co=1 iff rsv<rtv unsigned (borrow).
  - op 0, fn 0x24 AND, fn 0x25 OR: bitwise.
  - op 0, fn 0x2A SLT: rdv=1 if rsv<rtv signed, else 0.
  - op 0, fn 0x00 SLL: rdv=rtv<<sh; result 0 if sh>=DATA_W.
  - op 8 ADDI: {Co,rdv}=rsv+simm, carry out of bit DATA_W-1.
  - op 0x0C ANDI: rsv&zimm. op 0x0D ORI: rsv|zimm.
  - op 4 BEQ: taken iff rsv==rtv.
  - Co is unchanged by every op except ADD, ADDI and SUB.
- S_STORE:
  - R-type writes regi[rd]; I-type ALU ops write regi[rt]; BEQ writes nothing.
  - Writes to register 0 are discarded.
  - PC <= PC+4, or PC+4+(simm<<2) if the branch is taken, modulo 2^PC_W.
  - Retire=1; next state S_FETCH.
- S_HALT: Halt=1, IReq=0, no register or PC updates. Leave only by reset.
- Arithmetic wraps modulo 2^DATA_W.

## Timing
- Reset (Rst=0 at an edge, from any state, including mid-fetch or mid-store):
  - State=S_WAIT, PC=RESET_PC, all regi=0, IR=0.
  - Co=0, Halt=0, Retire=0, IReq=0.
  - An in-flight store is abandoned.
- After Rst rises: one S_WAIT cycle, then IReq=1 in the next cycle.
- Zero-wait fetch (IValid=1 in the first S_FETCH cycle):
  - 4 cycles per instruction: FETCH, DECODE, EXECUTE, STORE.
  - Retire is high in the STORE cycle; the register write is visible on DbgData in the following cycle.
- Each cycle of IValid=0 in S_FETCH adds one cycle.
- IValid while IReq=0 is ignored.
- IAddr is stable throughout S_FETCH.
- Halt rises in the cycle after the DECODE cycle of the offending instruction. That instruction never pulses Retire.
- An rs/rt read of a register written by the previous instruction sees the new value; no hazards exist in a multi-cycle design.

## Test plan
- Reset, then IData=0x20080001 (ADDI $8,$0,1) with IValid=1 -> Retire in the 4th cycle after IReq first rises; DbgAddr=8 shows 1; IAddr then 4; Co=0.
- Sequence ADDI $9,$0,-1 (0x2009FFFF); ADDI $10,$9,1 (0x212A0001) -> regi[9]=0xFFFFFFFF; regi[10]=0 with Co=1 (DATA_W=32).
- Sequence ADDI $1,$0,5; ADDI $2,$0,7; SUB $3,$1,$2; SLT $4,$1,$2 -> regi[3]=0xFFFFFFFE with Co=1; regi[4]=1.
- BEQ $0,$0,+2 (0x10000002) at PC=0 -> next IAddr=12.
- Same BEQ with rs=1 holding 5 -> next IAddr=4.
- IValid held low for 3 cycles -> IReq stays high and IAddr is constant; the instruction retires 3 cycles later than in the zero-wait case.
- Unsupported IData=0xFC000000 -> Halt=1, IReq=0 and no Retire.
- Rst=0 for one cycle during S_EXECUTE of an ADDI to $8 -> regi[8]=0 and PC=RESET_PC.
- Write to $0 (ADDI $0,$0,9) -> DbgAddr=0 reads 0.
- REG_COUNT=16 and DATA_W=16 instance: ADDI $20,... -> Halt; ADDI $5,$0,0x7FFF then ADDI $5,$5,1 -> regi[5]=0x8000 with Co=0.

Source files
------------

// File: rtl/gpp_multicycle.sv
// Multi-cycle MIPS-subset core: fetch handshake, R/I-type ALU ops and BEQ,
// carry flag, illegal-instruction halt, retire strobe and a debug register port.
module gpp_multicycle #(
  parameter int unsigned     DATA_W    = 32,
  parameter int unsigned     REG_COUNT = 32,
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic              IReq,
  output logic [PC_W-1:0]   IAddr,
  input  logic              IValid,
  input  logic [31:0]       IData,
  input  logic [4:0]        DbgAddr,
  output logic [DATA_W-1:0] DbgData,
  output logic              Retire,
  output logic              Co,
  output logic              Halt
);

  typedef enum logic [2:0] {
    S_WAIT, S_FETCH, S_DECODE, S_EXECUTE, S_STORE, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] rsv_q, rsv_d, rtv_q, rtv_d, rdv_q, rdv_d;
  logic              co_q, co_d, taken_q, taken_d;

  // Full 5-bit index space is kept; entries at or above REG_COUNT are never written.
  logic [DATA_W-1:0] regs_q [32];

  logic [5:0]        op, fn;
  logic [4:0]        rs, rt, rd, sh, wrIdx;
  logic [15:0]       imm;
  logic [DATA_W-1:0] simm, zimm;
  logic [PC_W-1:0]   brOff;
  logic [DATA_W:0]   sum;
  logic              legal, useRs, useRt, useRd, idxBad, wrEn;

  function automatic logic regOk(input logic [4:0] idx);
    return 32'(idx) < REG_COUNT;
  endfunction

  assign op  = ir_q[31:26];
  assign rs  = ir_q[25:21];
  assign rt  = ir_q[20:16];
  assign rd  = ir_q[15:11];
  assign sh  = ir_q[10:6];
  assign fn  = ir_q[5:0];
  assign imm = ir_q[15:0];

  always_comb begin
    simm       = {DATA_W{imm[15]}};
    simm[15:0] = imm;
    zimm       = '0;
    zimm[15:0] = imm;
    brOff      = {PC_W{imm[15]}};
    brOff[15:0] = imm;
    brOff      = brOff << 2;
  end

  always_comb begin
    legal = 1'b0;
    useRs = 1'b0;
    useRt = 1'b0;
    useRd = 1'b0;
    case (op)
      6'h00: case (fn)
        6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: begin
          legal = 1'b1; useRs = 1'b1; useRt = 1'b1; useRd = 1'b1;
        end
        6'h00: begin
          legal = 1'b1; useRt = 1'b1; useRd = 1'b1;
        end
        default: ;
      endcase
      6'h04, 6'h08, 6'h0C, 6'h0D: begin
        legal = 1'b1; useRs = 1'b1; useRt = 1'b1;
      end
      default: ;
    endcase
    idxBad = (useRs && !regOk(rs)) || (useRt && !regOk(rt)) || (useRd && !regOk(rd));
  end

  always_ff @(posedge Clk) begin
    if (!Rst) state_q <= S_WAIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:    state_d = S_FETCH;
      S_FETCH:   if (IValid) state_d = S_DECODE;
      S_DECODE:  state_d = (legal && !idxBad) ? S_EXECUTE : S_HALT;
      S_EXECUTE: state_d = S_STORE;
      S_STORE:   state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_WAIT;
    endcase
  end

  always_comb begin
    IReq    = (state_q == S_FETCH);
    Retire  = (state_q == S_STORE);
    Halt    = (state_q == S_HALT);
    IAddr   = pc_q;
    Co      = co_q;
    DbgData = regOk(DbgAddr) ? regs_q[DbgAddr] : '0;
  end

  always_comb begin
    ir_d  = ir_q;
    rsv_d = rsv_q;
    rtv_d = rtv_q;
    pc_d  = pc_q;
    case (state_q)
      S_FETCH:  if (IValid) ir_d = IData;
      S_DECODE: begin
        rsv_d = regOk(rs) ? regs_q[rs] : '0;
        rtv_d = regOk(rt) ? regs_q[rt] : '0;
      end
      S_STORE:  pc_d = pc_q + PC_W'(4) + (taken_q ? brOff : '0);
      default: ;
    endcase
  end

  // ALU: results are held in rdv_q/taken_q until the store cycle commits them.
  always_comb begin
    rdv_d   = rdv_q;
    co_d    = co_q;
    taken_d = taken_q;
    sum     = '0;
    if (state_q == S_EXECUTE) begin
      taken_d = 1'b0;
      case (op)
        6'h00: case (fn)
          6'h20: begin
            sum = {1'b0, rsv_q} + {1'b0, rtv_q};
            {co_d, rdv_d} = sum;
          end
          6'h22: begin
            rdv_d = rsv_q - rtv_q;
            co_d  = (rsv_q < rtv_q);
          end
          6'h24: rdv_d = rsv_q & rtv_q;
          6'h25: rdv_d = rsv_q | rtv_q;
          6'h2A: rdv_d = ($signed(rsv_q) < $signed(rtv_q)) ? DATA_W'(1) : '0;
          6'h00: rdv_d = (32'(sh) < DATA_W) ? (rtv_q << sh) : '0;
          default: ;
        endcase
        6'h08: begin
          sum = {1'b0, rsv_q} + {1'b0, simm};
          {co_d, rdv_d} = sum;
        end
        6'h0C: rdv_d = rsv_q & zimm;
        6'h0D: rdv_d = rsv_q | zimm;
        6'h04: taken_d = (rsv_q == rtv_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      rsv_q   <= '0;
      rtv_q   <= '0;
      rdv_q   <= '0;
      co_q    <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      rsv_q   <= rsv_d;
      rtv_q   <= rtv_d;
      rdv_q   <= rdv_d;
      co_q    <= co_d;
      taken_q <= taken_d;
    end
  end

  // R-type targets rd, I-type targets rt; BEQ and register 0 are never written.
  assign wrIdx = (op == 6'h00) ? rd : rt;
  assign wrEn  = (state_q == S_STORE) && (op != 6'h04) && (wrIdx != 5'd0) && regOk(wrIdx);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wrEn) begin
      regs_q[wrIdx] <= rdv_q;
    end
  end

endmodule
